// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, flush and stall.
// An optional skid entry keeps in_ready free of any combinational path from out_ready.
module pipe_stage_reg #(
   parameter int CTRL_W  = 16,
   parameter int DATA_W  = 128,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                xfer_in, xfer_out;

   assign out_valid = (state_q != EMPTY);

   generate
      if (SKID_EN != 0) begin : g_skid
         assign in_ready = (state_q != SKID);
      end else begin : g_noskid
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   assign xfer_in  = in_valid && in_ready;
   assign xfer_out = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      cnt_d       = cnt_q;

      // Flush drops held entries and any same-cycle input; data is left as is.
      if (flush) begin
         state_d     = EMPTY;
         main_ctrl_d = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (xfer_in) begin
                  state_d     = FULL;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            FULL: begin
               if (xfer_in && xfer_out) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (xfer_in && (SKID_EN != 0)) begin
                  state_d     = SKID;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (xfer_out) begin
                  state_d     = EMPTY;
                  main_ctrl_d = '0;
               end
            end
            SKID: begin
               if (xfer_out) begin
                  state_d     = FULL;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end
            end
            default: begin
               state_d     = EMPTY;
               main_ctrl_d = '0;
            end
         endcase
      end

      if (out_valid && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance (CNT_W=4) driven from a vector table,
// one single-register instance exercised by hand-written sequences.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Skid instance signals
   logic        a_rst_n, a_flush, a_iv, a_ir, a_ov, a_or;
   logic [7:0]  a_ic, a_oc;
   logic [15:0] a_id, a_od;
   logic [3:0]  a_sc;

   // Single-register instance signals
   logic        b_rst_n, b_flush, b_iv, b_ir, b_ov, b_or;
   logic [7:0]  b_ic, b_oc;
   logic [15:0] b_id, b_od;
   logic [7:0]  b_sc;

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID_EN(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst_n(a_rst_n), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
      .in_ctrl(a_ic), .in_data(a_id), .out_valid(a_ov), .out_ready(a_or),
      .out_ctrl(a_oc), .out_data(a_od), .stall_cnt(a_sc));

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID_EN(0), .CNT_W(8)) u_noskid (
      .clk(clk), .rst_n(b_rst_n), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
      .in_ctrl(b_ic), .in_data(b_id), .out_valid(b_ov), .out_ready(b_or),
      .out_ctrl(b_oc), .out_data(b_od), .stall_cnt(b_sc));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic rst_n, flush, iv;
      int   k;
      logic ordy;
      logic e_ir, e_ov;
      int   e_ck, e_dk;
      int   e_sc;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [7:0] C(int k);
      return (k == 0) ? 8'h00 : 8'h40 + k[7:0];
   endfunction

   function automatic logic [15:0] D(int k);
      return (k == 0) ? 16'h0000 : 16'hD000 + k[15:0];
   endfunction

   function automatic vec_t mk(logic r, logic f, logic iv, int k, logic o,
                               logic ir, logic ov, int ck, int dk, int sc);
      vec_t v;
      v.rst_n = r; v.flush = f; v.iv = iv; v.k = k; v.ordy = o;
      v.e_ir = ir; v.e_ov = ov; v.e_ck = ck; v.e_dk = dk; v.e_sc = sc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic b_step(logic r, logic f, logic iv, int k, logic o);
      b_rst_n = r; b_flush = f; b_iv = iv; b_ic = C(k); b_id = D(k); b_or = o;
      @(posedge clk); #1;
   endtask

   initial begin
      a_rst_n = 1'b0; a_flush = 1'b0; a_iv = 1'b0; a_ic = '0; a_id = '0; a_or = 1'b1;
      b_rst_n = 1'b0; b_flush = 1'b0; b_iv = 1'b0; b_ic = '0; b_id = '0; b_or = 1'b1;

      // reset (handshake ignored), then stream 1..8
      tbl.push_back(mk(0,0,1,1,1, 1,0,0,0,0));
      tbl.push_back(mk(0,0,1,1,1, 1,0,0,0,0));
      for (int k = 1; k <= 8; k++) tbl.push_back(mk(1,0,1,k,1, 1,1,k,k,0));
      tbl.push_back(mk(1,0,0,0,1, 1,0,0,8,0));
      // skid fill: A=9 B=10 C=11, three stall cycles
      tbl.push_back(mk(1,0,1,9,1,  1,1,9,9,0));
      tbl.push_back(mk(1,0,1,10,0, 0,1,9,9,1));
      tbl.push_back(mk(1,0,1,11,0, 0,1,9,9,2));
      tbl.push_back(mk(1,0,1,11,0, 0,1,9,9,3));
      tbl.push_back(mk(1,0,1,11,1, 1,1,10,10,3));
      tbl.push_back(mk(1,0,1,11,1, 1,1,11,11,3));
      tbl.push_back(mk(1,0,0,0,1,  1,0,0,11,3));
      // flush with main X=12, skid Y=13, input Z=14
      tbl.push_back(mk(1,0,1,12,1, 1,1,12,12,3));
      tbl.push_back(mk(1,0,1,13,0, 0,1,12,12,4));
      tbl.push_back(mk(1,1,1,14,0, 1,0,0,12,4));
      tbl.push_back(mk(1,0,0,0,1,  1,0,0,12,4));
      // reset while in SKID (P=15, Q=16)
      tbl.push_back(mk(1,0,1,15,1, 1,1,15,15,4));
      tbl.push_back(mk(1,0,1,16,0, 0,1,15,15,5));
      tbl.push_back(mk(0,0,1,17,1, 1,0,0,0,0));
      // flush drops an acceptable input from EMPTY, and a transfer-out in FULL
      tbl.push_back(mk(1,1,1,18,1, 1,0,0,0,0));
      tbl.push_back(mk(1,0,1,19,1, 1,1,19,19,0));
      tbl.push_back(mk(1,1,1,20,1, 1,0,0,19,0));

      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         a_rst_n = tbl[i].rst_n; a_flush = tbl[i].flush; a_iv = tbl[i].iv;
         a_ic = C(tbl[i].k); a_id = D(tbl[i].k); a_or = tbl[i].ordy;
         @(posedge clk); #1;
         chk($sformatf("v%0d.in_ready", i),  {31'd0, a_ir}, {31'd0, tbl[i].e_ir});
         chk($sformatf("v%0d.out_valid", i), {31'd0, a_ov}, {31'd0, tbl[i].e_ov});
         chk($sformatf("v%0d.out_ctrl", i),  {24'd0, a_oc}, {24'd0, C(tbl[i].e_ck)});
         chk($sformatf("v%0d.out_data", i),  {16'd0, a_od}, {16'd0, D(tbl[i].e_dk)});
         chk($sformatf("v%0d.stall_cnt", i), {28'd0, a_sc}, tbl[i].e_sc);
      end

      // counter saturation: 20 stall cycles on a held entry, then one reset edge
      a_rst_n = 1'b1; a_flush = 1'b0; a_iv = 1'b1; a_ic = C(21); a_id = D(21); a_or = 1'b1;
      @(posedge clk); #1;
      a_iv = 1'b0; a_or = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (i == 13) chk("sat.cnt14", {28'd0, a_sc}, 32'd14);
      end
      chk("sat.cnt_held", {28'd0, a_sc}, 32'd15);
      chk("sat.data_held", {16'd0, a_od}, {16'd0, D(21)});
      chk("sat.ctrl_held", {24'd0, a_oc}, {24'd0, C(21)});
      a_rst_n = 1'b0;
      @(posedge clk); #1;
      chk("sat.cnt_reset", {28'd0, a_sc}, 32'd0);
      chk("sat.valid_reset", {31'd0, a_ov}, 32'd0);

      // single-register instance: stream, stall with combinational in_ready, replace
      b_step(0,0,0,0,1);
      chk("b.reset_ir", {31'd0, b_ir}, 32'd1);
      chk("b.reset_ov", {31'd0, b_ov}, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         b_step(1,0,1,k,1);
         chk($sformatf("b.stream%0d", k), {16'd0, b_od}, {16'd0, D(k)});
         chk($sformatf("b.stream%0d_ov", k), {31'd0, b_ov}, 32'd1);
      end
      b_or = 1'b0; b_iv = 1'b1; b_ic = C(4); b_id = D(4);
      #1;
      chk("b.stall_ir_same_cycle", {31'd0, b_ir}, 32'd0);
      @(posedge clk); #1;
      chk("b.stall_data_held", {16'd0, b_od}, {16'd0, D(3)});
      chk("b.stall_ctrl_held", {24'd0, b_oc}, {24'd0, C(3)});
      chk("b.stall_cnt", {24'd0, b_sc}, 32'd1);
      b_or = 1'b1;
      #1;
      chk("b.release_ir", {31'd0, b_ir}, 32'd1);
      @(posedge clk); #1;
      chk("b.replace_data", {16'd0, b_od}, {16'd0, D(4)});
      b_step(1,0,0,0,1);
      chk("b.drain_ov", {31'd0, b_ov}, 32'd0);
      chk("b.drain_ctrl", {24'd0, b_oc}, 32'd0);
      chk("b.drain_data", {16'd0, b_od}, {16'd0, D(4)});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
